render_scan_controller: RTL

Frame sequencer for the shape-render pipeline. On `start` it issues one pixel per cycle in raster order (x fastest) at the head of the chained shape renderers, with a programmable background colour. It also tracks in-flight pixels through a valid delay line matched to the pipeline latency. Issue is throttled by a credit counter from the downstream sink, and the block signals frame completion once the pipeline has drained.

---
 rtl/render_scan_controller_if.sv | 35 +++
 rtl/render_scan_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/render_scan_controller_if.sv
// render_scan_controller_if: control, credit, pipeline-return and pixel-issue
// signals of the render scan controller, bundled for module ports.
// master: frame host / downstream sink side. slave: the scan controller.
interface render_scan_controller_if;
    logic               start;
    logic               abort;
    logic               credit_return;
    logic [7:0]         res_r;
    logic [7:0]         res_g;
    logic [7:0]         res_b;
    logic               busy;
    logic               done;
    logic signed [10:0] pix_x;
    logic signed [11:0] pix_y;
    logic [7:0]         pix_r;
    logic [7:0]         pix_g;
    logic [7:0]         pix_b;
    logic               pix_valid;
    logic               pipe_valid;
    logic               pipe_last;
    logic [15:0]        frame_count;
    logic [23:0]        checksum;

    modport master (
        output start, abort, credit_return, res_r, res_g, res_b,
        input  busy, done, pix_x, pix_y, pix_r, pix_g, pix_b,
               pix_valid, pipe_valid, pipe_last, frame_count, checksum
    );

    modport slave (
        input  start, abort, credit_return, res_r, res_g, res_b,
        output busy, done, pix_x, pix_y, pix_r, pix_g, pix_b,
               pix_valid, pipe_valid, pipe_last, frame_count, checksum
    );
endinterface

// File: rtl/render_scan_controller.sv
// render_scan_controller: raster-order pixel issue for the shape-render
// pipeline, credit-throttled, with a {valid,last} delay line matched to the
// pipeline latency and a done pulse once the pipeline has drained.
// Optional feature macro: RENDER_CHECKSUM_EN (frame colour checksum of res_*).
module render_scan_controller #(
    parameter int         WIDTH    = 640,
    parameter int         HEIGHT   = 480,
    parameter int         PIPE_LAT = 3,
    parameter int         CREDITS  = 8,
    parameter logic [7:0] BG_R     = 8'h00,
    parameter logic [7:0] BG_G     = 8'h00,
    parameter logic [7:0] BG_B     = 8'h00
) (
    input logic             clk,
    input logic             rst,
    render_scan_controller_if.slave bus
);
    localparam int                CW       = $clog2(CREDITS + 1);
    localparam logic [10:0]       X_LAST   = 11'(WIDTH - 1);
    localparam logic [11:0]       Y_LAST   = 12'(HEIGHT - 1);
    localparam logic [CW-1:0]     CRED_MAX = CW'(CREDITS);
    // Stages that still feed the output; the final stage empties on the done edge.
    localparam logic [PIPE_LAT-1:0] INNER_MASK =
        PIPE_LAT'((64'd1 << (PIPE_LAT - 1)) - 64'd1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t              state, state_next;
    logic [10:0]         x_cnt, x_next;
    logic [11:0]         y_cnt, y_next;
    logic [CW-1:0]       credits;
    logic                issue, tag_last, accept, finish, drained;
    logic                pix_valid_q, pix_last_q;
    logic [10:0]         pix_x_q;
    logic [11:0]         pix_y_q;
    logic                busy_q, done_q;
    logic [15:0]         frame_count_q;
    logic [PIPE_LAT-1:0] dl_valid, dl_last;

    // Pixel register and delay line both empty apart from the stage leaving now.
    assign drained = !pix_valid_q && ((dl_valid & INNER_MASK) == '0);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state, issue decision and raster counter advance
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        tag_last   = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        x_next     = x_cnt;
        y_next     = y_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_next = DRAIN;
                end else if (credits != '0) begin
                    issue = 1'b1;
                    if (x_cnt == X_LAST) begin
                        x_next = '0;
                        if (y_cnt == Y_LAST) begin
                            tag_last   = 1'b1;
                            state_next = DRAIN;
                        end else begin
                            y_next = y_cnt + 12'd1;
                        end
                    end else begin
                        x_next = x_cnt + 11'd1;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs, counters, credits and {valid,last} delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt         <= '0;
            y_cnt         <= '0;
            credits       <= CRED_MAX;
            pix_valid_q   <= 1'b0;
            pix_last_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= '0;
            dl_valid      <= '0;
            dl_last       <= '0;
        end else begin
            x_cnt       <= x_next;
            y_cnt       <= y_next;
            pix_valid_q <= issue;
            pix_last_q  <= tag_last;
            if (issue) begin
                pix_x_q <= x_cnt;
                pix_y_q <= y_cnt;
            end
            if (issue && !bus.credit_return)
                credits <= credits - 1'b1;
            else if (!issue && bus.credit_return && credits != CRED_MAX)
                credits <= credits + 1'b1;
            // busy lags entry to SCAN by one cycle and drops together with done
            busy_q <= (state != IDLE) && (state_next != IDLE);
            done_q <= finish;
            if (finish) frame_count_q <= frame_count_q + 16'd1;
            dl_valid <= PIPE_LAT'({dl_valid, pix_valid_q});
            dl_last  <= PIPE_LAT'({dl_last, pix_last_q});
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_r       = BG_R;
    assign bus.pix_g       = BG_G;
    assign bus.pix_b       = BG_B;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pipe_valid  = dl_valid[PIPE_LAT-1];
    assign bus.pipe_last   = dl_last[PIPE_LAT-1];
    assign bus.frame_count = frame_count_q;

`ifdef RENDER_CHECKSUM_EN
    logic [23:0] checksum_q;

    // Frame colour checksum: cleared on accepted start, sums valid results
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            checksum_q <= '0;
        else if (accept)
            checksum_q <= '0;
        else if (dl_valid[PIPE_LAT-1])
            checksum_q <= checksum_q + {bus.res_r, bus.res_g, bus.res_b};
    end

    assign bus.checksum = checksum_q;
`else
    logic unused_res;
    assign unused_res   = ^{bus.res_r, bus.res_g, bus.res_b, accept};
    assign bus.checksum = '0;
`endif
endmodule
